// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for the 1:4 buffered demux.
//   NUM_CH   - number of output channels
//   SEL_W    - width of the channel select
//   ch_sel_t - channel select type
//   cnt_w()  - width of an occupancy counter for a FIFO of the given depth
//              (one extra bit so that "full" is representable)
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered head, used once per demux channel.
//   clk, rst_n - clock, asynchronous active-low reset (clears pointers and count only)
//   push       - write push_data at the tail (ignored when full)
//   pop        - advance the head (ignored when empty)
//   head_data  - current head word, forced to 0 while empty
//   count      - occupancy, 0..DEPTH
//   full/empty - count == DEPTH / count == 0
// DEPTH must be a power of two and at least 2, so the pointers wrap on
// their own at the natural binary rollover.
module sync_fifo
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     head_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic                  do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage is deliberately not reset; stale contents are unreachable once
  // the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      // Simultaneous push and pop leaves the count unchanged.
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/demux_1x4_buffered.sv
// demux_1x4_buffered: routes one valid/ready producer stream to one of four
// consumer channels, each behind its own FIFO, so a stalled consumer only
// blocks transfers aimed at it.
//   clk, rst_n  - clock, asynchronous active-low reset (empties every FIFO)
//   in_valid    - producer has a transfer
//   in_ready    - FIFO selected by in_sel is not full
//   in_sel      - destination channel 0..3 (only meaningful while in_valid)
//   in_data     - payload
//   out_valid   - bit k: FIFO k non-empty
//   out_ready   - bit k: consumer k accepts
//   out_data    - channel k head at [k*DATA_WIDTH +: DATA_WIDTH], 0 when empty
//   out_count   - channel k occupancy, packed the same way as out_data
module demux_1x4_buffered
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  ch_sel_t                          in_sel,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic [NUM_CH-1:0]                out_valid,
  input  logic [NUM_CH-1:0]                out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]     out_data,
  output logic [NUM_CH*cnt_w(DEPTH)-1:0]   out_count
);

  localparam int CW = cnt_w(DEPTH);

  logic [NUM_CH-1:0]                 push_en, full, empty;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] head;
  logic [NUM_CH-1:0][CW-1:0]         cnt;

  // Readiness comes only from registered fullness, never from out_ready:
  // a full channel stays blocked even on the cycle its consumer pops.
  assign in_ready = ~full[in_sel];

  always_comb begin
    push_en = '0;
    if (in_valid && in_ready) push_en[in_sel] = 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_en[k]),
      .push_data (in_data),
      .pop       (out_ready[k]),
      .head_data (head[k]),
      .count     (cnt[k]),
      .full      (full[k]),
      .empty     (empty[k])
    );
    assign out_valid[k] = ~empty[k];
  end

  // Packed 2-D arrays flatten with element k at [k*W +: W].
  assign out_data  = head;
  assign out_count = cnt;

endmodule

// File: tb/tb_demux_1x4_buffered.sv
module tb_demux_1x4_buffered;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_sel = '0;
  logic [DW-1:0] in_data = '0;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = '0;
  logic [4*DW-1:0] out_data;
  logic [4*CW-1:0] out_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1x4_buffered #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  function automatic logic [DW-1:0] dat(input int k);
    return out_data[k*DW +: DW];
  endfunction

  function automatic logic [CW-1:0] cnt(input int k);
    return out_count[k*CW +: CW];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = '0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_during: got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL rst_out_valid: got %b want 0000", out_valid); end
    checks++; if (out_count !== 8'h00) begin errors++; $display("FAIL rst_out_count: got %h want 00", out_count); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    for (int s = 0; s < 4; s++) begin
      in_sel = s[1:0]; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready sel=%0d: got %b want 1", s, in_ready); end
    end
  endtask

  task automatic test_single_route();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hA5A5_0001; out_ready = 4'b0000; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL route_valid: got %b want 0100", out_valid); end
    checks++; if (dat(2) !== 32'hA5A5_0001) begin errors++; $display("FAIL route_data: got %h want a5a50001", dat(2)); end
    checks++; if (out_count !== 8'b00_01_00_00) begin errors++; $display("FAIL route_count: got %b want 00010000", out_count); end
    out_ready = 4'b0100;
    @(negedge clk);
    out_ready = '0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL route_drain: got %b want 0000", out_valid); end
  endtask

  task automatic test_fill_block();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h11;
    @(negedge clk);
    in_data = 32'h22;
    @(negedge clk);
    in_data = 32'h33;
    checks++; if (cnt(1) !== 2'd2) begin errors++; $display("FAIL fill_count1: got %0d want 2", cnt(1)); end
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL fill_valid: got %b want 0010", out_valid); end
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_blocked: got %b want 0", in_ready); end
    out_ready = 4'b0010; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_blocked_with_pop: got %b want 0", in_ready); end
    out_ready = 4'b0000;
    in_sel = 2'd3; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_other_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 4'b1010) begin errors++; $display("FAIL fill_valid2: got %b want 1010", out_valid); end
    checks++; if (cnt(1) !== 2'd2 || cnt(3) !== 2'd1) begin errors++; $display("FAIL fill_counts: got c1=%0d c3=%0d want c1=2 c3=1", cnt(1), cnt(3)); end
    checks++; if (dat(3) !== 32'h33) begin errors++; $display("FAIL fill_data3: got %h want 33", dat(3)); end
    checks++; if (dat(1) !== 32'h11) begin errors++; $display("FAIL fill_head1a: got %h want 11", dat(1)); end
    out_ready = 4'b1010;
    @(negedge clk);
    checks++; if (dat(1) !== 32'h22) begin errors++; $display("FAIL fill_head1b: got %h want 22", dat(1)); end
    checks++; if (cnt(1) !== 2'd1 || out_valid !== 4'b0010) begin errors++; $display("FAIL fill_after_pop: got c1=%0d v=%b want c1=1 v=0010", cnt(1), out_valid); end
    @(negedge clk);
    out_ready = '0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL fill_drain: got %b want 0000", out_valid); end
  endtask

  task automatic test_concurrent();
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hC0;
    @(negedge clk);
    in_sel = 2'd3; in_data = 32'hC3;
    @(negedge clk);
    in_sel = 2'd0; in_data = 32'hC1; out_ready = 4'b1001; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL conc_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 4'b1001 || dat(0) !== 32'hC0 || dat(3) !== 32'hC3) begin errors++; $display("FAIL conc_preload: got v=%b d0=%h d3=%h want v=1001 d0=c0 d3=c3", out_valid, dat(0), dat(3)); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = '0;
    checks++; if (cnt(0) !== 2'd1 || cnt(3) !== 2'd0) begin errors++; $display("FAIL conc_counts: got c0=%0d c3=%0d want c0=1 c3=0", cnt(0), cnt(3)); end
    checks++; if (out_valid !== 4'b0001 || dat(0) !== 32'hC1) begin errors++; $display("FAIL conc_order: got v=%b d0=%h want v=0001 d0=c1", out_valid, dat(0)); end
    out_ready = 4'b0001;
    @(negedge clk);
    out_ready = '0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL conc_drain: got %b want 0000", out_valid); end
  endtask

  task automatic test_empty_pop();
    @(negedge clk);
    out_ready = 4'b1111;
    @(negedge clk);
    checks++; if (out_count !== 8'h00 || out_valid !== 4'b0000) begin errors++; $display("FAIL empty_underflow: got cnt=%h v=%b want cnt=00 v=0000", out_count, out_valid); end
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h77;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (cnt(2) !== 2'd1 || out_valid !== 4'b0100 || dat(2) !== 32'h77) begin errors++; $display("FAIL empty_push_pop: got c2=%0d v=%b d2=%h want c2=1 v=0100 d2=77", cnt(2), out_valid, dat(2)); end
    @(negedge clk);
    out_ready = '0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL empty_drain: got %b want 0000", out_valid); end
  endtask

  task automatic test_stress();
    logic [DW-1:0] q [4][$];
    logic [3:0]    exp_v;
    logic [4*CW-1:0] exp_c;
    logic          exp_rdy;
    logic          hold;
    hold = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = $urandom;
      end
      // Drain phase at the end so every queued word is delivered.
      out_ready = (cyc >= 2990) ? 4'b1111 : 4'($urandom_range(0, 15));
      if (cyc >= 2990) in_valid = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
        exp_v[k] = (q[k].size() != 0);
        exp_c[k*CW +: CW] = CW'(q[k].size());
      end
      exp_rdy = (q[in_sel].size() != DEPTH);
      checks++; if (out_valid !== exp_v || out_count !== exp_c || in_ready !== exp_rdy) begin errors++; $display("FAIL stress_state cyc=%0d: got v=%b c=%h rdy=%b want v=%b c=%h rdy=%b", cyc, out_valid, out_count, in_ready, exp_v, exp_c, exp_rdy); end
      for (int k = 0; k < 4; k++) begin
        if (q[k].size() != 0 && out_ready[k]) begin
          checks++; if (dat(k) !== q[k][0]) begin errors++; $display("FAIL stress_data cyc=%0d ch=%0d: got %h want %h", cyc, k, dat(k), q[k][0]); end
          void'(q[k].pop_front());
        end
      end
      if (in_valid && exp_rdy) q[in_sel].push_back(in_data);
      hold = in_valid && !exp_rdy;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = '0;
    checks++; if (out_valid !== 4'b0000 || q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0) begin errors++; $display("FAIL stress_final: got v=%b want 0000 with empty model", out_valid); end
  endtask

  task automatic test_mid_reset();
    logic [1:0]    sels [6];
    sels = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    out_ready = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = sels[i]; in_data = 32'h5000 + 32'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_count !== {2'd1, 2'd2, 2'd1, 2'd2}) begin errors++; $display("FAIL mrst_preload: got %b want 01100110", out_count); end
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hDEAD;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 4'b0000 || out_count !== 8'h00 || out_data !== '0) begin errors++; $display("FAIL mrst_async: got v=%b c=%h d=%h want all 0", out_valid, out_count, out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (cnt(0) !== 2'd1 || dat(0) !== 32'hBEEF || out_valid !== 4'b0001) begin errors++; $display("FAIL mrst_new_word: got c0=%0d d0=%h v=%b want c0=1 d0=beef v=0001", cnt(0), dat(0), out_valid); end
    out_ready = 4'b0001;
    @(negedge clk);
    out_ready = '0;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL mrst_drain: got %b want 0000", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_fill_block();
    test_concurrent();
    test_empty_pop();
    test_stress();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
